timer_period_counter: RTL

//  Per-channel period counter of the APB advanced timer; sits directly downstream of the timer control stage.
//  - Consumes its ctrl_* strobes and the prescaled count event.
//  - Produces the counter value for the comparators.
//  - Returns the shadow-update acknowledge that drives the control stage's cnt_update_i.
//  - Holds shadow copies of start/end/mode so reprogramming takes effect only at a period boundary.

---
 rtl/timer_pkg.sv | 7 +
 rtl/timer_cnt_shadow.sv | 85 ++++++++
 rtl/timer_period_counter.sv | 115 +++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the advanced timer period counter.
// TIMER_CNT_STEP_EN (in the users of this package) enables a programmable count step.
package timer_pkg;
  typedef enum logic {CNT_SAWTOOTH, CNT_TRIANGLE} cnt_mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} cnt_dir_e;
  localparam int TIMER_NUM_BITS = 16;
endpackage

// File: rtl/timer_cnt_shadow.sv
// Pending-reload flag and shadow copies of start/end/mode (and step with TIMER_CNT_STEP_EN).
// Shadows only change when the counter asks for a load at a period boundary.
import timer_pkg::*;

module timer_cnt_shadow #(
  parameter int NUM_BITS = TIMER_NUM_BITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic                cfg_mode_i,
`ifdef TIMER_CNT_STEP_EN
  input  logic [NUM_BITS-1:0] cfg_step_i,
`endif
  input  logic                upd_req_i,
  input  logic                load_evt_i,
  output logic [NUM_BITS-1:0] start_o,
  output logic [NUM_BITS-1:0] end_o,
  output cnt_mode_e           mode_o,
  output logic [NUM_BITS-1:0] step_o,
  output logic                load_o
);

  logic                pending_q, pending_d;
  logic [NUM_BITS-1:0] start_q, start_d;
  logic [NUM_BITS-1:0] end_q, end_d;
  cnt_mode_e           mode_q, mode_d;

  // A request in the same cycle as the boundary counts as pending.
  assign load_o = load_evt_i && (pending_q || upd_req_i);

  always_comb begin
    pending_d = pending_q;
    start_d   = start_q;
    end_d     = end_q;
    mode_d    = mode_q;
    if (load_o) begin
      pending_d = 1'b0;
      start_d   = cfg_start_i;
      end_d     = cfg_end_i;
      mode_d    = cnt_mode_e'(cfg_mode_i);
    end else if (upd_req_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= 1'b0;
      start_q   <= '0;
      end_q     <= '0;
      mode_q    <= CNT_SAWTOOTH;
    end else begin
      pending_q <= pending_d;
      start_q   <= start_d;
      end_q     <= end_d;
      mode_q    <= mode_d;
    end
  end

`ifdef TIMER_CNT_STEP_EN
  logic [NUM_BITS-1:0] step_q, step_d;

  // A zero step would stall the counter forever, so it is promoted to 1.
  always_comb begin
    step_d = step_q;
    if (load_o) step_d = (cfg_step_i == '0) ? NUM_BITS'(1) : cfg_step_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) step_q <= NUM_BITS'(1);
    else         step_q <= step_d;
  end

  assign step_o = step_q;
`else
  assign step_o = NUM_BITS'(1);
`endif

  assign start_o = start_q;
  assign end_o   = end_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/timer_period_counter.sv
// Per-channel period counter: sawtooth or triangle counting between shadowed start/end.
// TIMER_CNT_STEP_EN adds the cfg_step_i port and a shadowed step; otherwise the step is 1.
import timer_pkg::*;

module timer_period_counter #(
  parameter int NUM_BITS = TIMER_NUM_BITS
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic                cfg_mode_i,
`ifdef TIMER_CNT_STEP_EN
  input  logic [NUM_BITS-1:0] cfg_step_i,
`endif
  input  logic                ctrl_active_i,
  input  logic                ctrl_rst_i,
  input  logic                ctrl_cnt_upd_i,
  input  logic                evt_i,
  output logic [NUM_BITS-1:0] counter_o,
  output logic                end_o,
  output logic                update_o,
  output logic                dir_o
);

  logic [NUM_BITS-1:0] cnt_q, cnt_d;
  cnt_dir_e            dir_q, dir_d;
  logic                end_q, end_d;
  logic                upd_q, upd_d;

  logic [NUM_BITS-1:0] start_r, end_r, step_r;
  cnt_mode_e           mode_r;
  logic                load;
  logic                tick, terminal, turn;
  logic [NUM_BITS:0]   sum, diff;
  logic [NUM_BITS-1:0] up_val, dn_val;

  timer_cnt_shadow #(.NUM_BITS(NUM_BITS)) u_shadow (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cfg_start_i (cfg_start_i),
    .cfg_end_i   (cfg_end_i),
    .cfg_mode_i  (cfg_mode_i),
`ifdef TIMER_CNT_STEP_EN
    .cfg_step_i  (cfg_step_i),
`endif
    .upd_req_i   (ctrl_cnt_upd_i),
    .load_evt_i  (ctrl_rst_i || terminal),
    .start_o     (start_r),
    .end_o       (end_r),
    .mode_o      (mode_r),
    .step_o      (step_r),
    .load_o      (load)
  );

  assign tick = ctrl_active_i && evt_i;

  // Extra carry/borrow bit keeps the clamps correct near the top and bottom of the range.
  assign sum    = {1'b0, cnt_q} + {1'b0, step_r};
  assign diff   = {1'b0, cnt_q} - {1'b0, step_r};
  assign up_val = (sum > {1'b0, end_r}) ? end_r : sum[NUM_BITS-1:0];
  assign dn_val = (diff[NUM_BITS] || (diff[NUM_BITS-1:0] < start_r)) ? start_r
                                                                     : diff[NUM_BITS-1:0];

  assign terminal = tick && !ctrl_rst_i &&
                    (((mode_r == CNT_SAWTOOTH) && (cnt_q == end_r)) ||
                     ((mode_r == CNT_TRIANGLE) && (dir_q == DIR_DOWN) && (cnt_q == start_r)));
  assign turn     = (mode_r == CNT_TRIANGLE) && (dir_q == DIR_UP) && (cnt_q == end_r);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    end_d = 1'b0;
    upd_d = load;
    if (ctrl_rst_i) begin
      dir_d = DIR_UP;
      cnt_d = load ? cfg_start_i : start_r;
    end else if (tick) begin
      if (terminal) begin
        end_d = 1'b1;
        dir_d = DIR_UP;
        if (load)                        cnt_d = cfg_start_i;
        else if (mode_r == CNT_SAWTOOTH) cnt_d = start_r;
        else                             cnt_d = up_val;
      end else if (turn) begin
        dir_d = DIR_DOWN;
        cnt_d = dn_val;
      end else if (dir_q == DIR_DOWN) begin
        cnt_d = dn_val;
      end else begin
        cnt_d = up_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
      end_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      end_q <= end_d;
      upd_q <= upd_d;
    end
  end

  assign counter_o = cnt_q;
  assign end_o     = end_q;
  assign update_o  = upd_q;
  assign dir_o     = dir_q;

endmodule
